// File: rtl/video_meta_if.sv
// Raster metadata bundle: OSD/scanline configuration in, per-pixel position and flags out.
// The generator uses the master modport; the pixel/alpha stage uses the slave modport.
interface video_meta_if;
  logic       osd_enable;
  logic [9:0] osd_x;
  logic [9:0] osd_y;
  logic [5:0] osd_cols;
  logic [4:0] osd_rows;
  logic       scanline_enable;
  logic       scanline_odd;

  logic [9:0] counter_x;
  logic [9:0] counter_y;
  logic       frame_start;
  logic       isDrawAreaVGA;
  logic       isOsdBgArea;
  logic       isOsdTextArea;
  logic       isScanline;
  logic [5:0] char_col;
  logic [4:0] char_row;
  logic [2:0] glyph_x;
  logic [3:0] glyph_y;

  modport master (
    input  osd_enable, osd_x, osd_y, osd_cols, osd_rows, scanline_enable, scanline_odd,
    output counter_x, counter_y, frame_start, isDrawAreaVGA, isOsdBgArea, isOsdTextArea,
           isScanline, char_col, char_row, glyph_x, glyph_y
  );

  modport slave (
    output osd_enable, osd_x, osd_y, osd_cols, osd_rows, scanline_enable, scanline_odd,
    input  counter_x, counter_y, frame_start, isDrawAreaVGA, isOsdBgArea, isOsdTextArea,
           isScanline, char_col, char_row, glyph_x, glyph_y
  );
endinterface

// File: rtl/video_meta_gen.sv
// Raster position, draw/OSD/scanline flags and glyph addressing, one register stage deep.
// Define VIDEO_META_FRAME_SYNC_EN to latch the configuration only at frame boundaries.
module video_meta_gen #(
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned OSD_BORDER = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  video_meta_if.master vm
);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       load;
  logic       x_wrap, y_wrap;

  // Shadow configuration
  logic       en_q, en_d, sen_q, sen_d, sodd_q, sodd_d;
  logic [9:0] ox_q, ox_d, oy_q, oy_d;
  logic [5:0] cols_q, cols_d;
  logic [4:0] rows_q, rows_d;

  // Output stage
  logic [9:0] cx_q, cx_d, cy_q, cy_d;
  logic       fs_q, fs_d, draw_q, draw_d, bg_q, bg_d, text_q, text_d, scan_q, scan_d;
  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [2:0] gx_q, gx_d;
  logic [3:0] gy_q, gy_d;

  logic [10:0] px, py, tr_x0, tr_x1, tr_y0, tr_y1, br_x0, br_x1, br_y0, br_y1;
  logic        in_tr, in_br;
  logic [8:0]  dx, dy;

`ifdef VIDEO_META_FRAME_SYNC_EN
  logic first_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) first_q <= 1'b1;
    else          first_q <= 1'b0;
  end

  assign load = first_q | (x_wrap & y_wrap);
`else
  assign load = 1'b1;
`endif

  always_comb begin
    x_wrap = (x_q == 10'(H_TOTAL - 1));
    y_wrap = (y_q == 10'(V_TOTAL - 1));
    x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
    y_d    = y_q;
    if (x_wrap) y_d = y_wrap ? 10'd0 : y_q + 10'd1;

    en_d   = load ? vm.osd_enable      : en_q;
    ox_d   = load ? vm.osd_x           : ox_q;
    oy_d   = load ? vm.osd_y           : oy_q;
    cols_d = load ? vm.osd_cols        : cols_q;
    rows_d = load ? vm.osd_rows        : rows_q;
    sen_d  = load ? vm.scanline_enable : sen_q;
    sodd_d = load ? vm.scanline_odd    : sodd_q;
  end

  // Rectangle bounds are 11 bits so the right/bottom edges never wrap.
  always_comb begin
    px    = {1'b0, x_q};
    py    = {1'b0, y_q};
    tr_x0 = {1'b0, ox_q};
    tr_y0 = {1'b0, oy_q};
    tr_x1 = tr_x0 + {2'b00, cols_q, 3'b000};
    tr_y1 = tr_y0 + {2'b00, rows_q, 4'b0000};
    br_x0 = (ox_q < 10'(OSD_BORDER)) ? 11'd0 : tr_x0 - 11'(OSD_BORDER);
    br_y0 = (oy_q < 10'(OSD_BORDER)) ? 11'd0 : tr_y0 - 11'(OSD_BORDER);
    br_x1 = tr_x1 + 11'(OSD_BORDER);
    br_y1 = tr_y1 + 11'(OSD_BORDER);
    in_tr = (px >= tr_x0) && (px < tr_x1) && (py >= tr_y0) && (py < tr_y1);
    in_br = (px >= br_x0) && (px < br_x1) && (py >= br_y0) && (py < br_y1);
    dx    = 9'(x_q - ox_q);
    dy    = 9'(y_q - oy_q);

    cx_d   = x_q;
    cy_d   = y_q;
    fs_d   = (x_q == 10'd0) && (y_q == 10'd0);
    draw_d = (x_q < 10'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));
    bg_d   = en_q && (cols_q != 6'd0) && (rows_q != 5'd0) && in_br && draw_d;
    text_d = bg_d && in_tr;
    scan_d = sen_q && draw_d && (y_q[0] == sodd_q);
    col_d  = text_d ? dx[8:3] : 6'd0;
    gx_d   = text_d ? dx[2:0] : 3'd0;
    row_d  = text_d ? dy[8:4] : 5'd0;
    gy_d   = text_d ? dy[3:0] : 4'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      en_q   <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
      cols_q <= '0;
      rows_q <= '0;
      sen_q  <= 1'b0;
      sodd_q <= 1'b0;
      cx_q   <= '0;
      cy_q   <= '0;
      fs_q   <= 1'b0;
      draw_q <= 1'b0;
      bg_q   <= 1'b0;
      text_q <= 1'b0;
      scan_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      gx_q   <= '0;
      gy_q   <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      en_q   <= en_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      cols_q <= cols_d;
      rows_q <= rows_d;
      sen_q  <= sen_d;
      sodd_q <= sodd_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      fs_q   <= fs_d;
      draw_q <= draw_d;
      bg_q   <= bg_d;
      text_q <= text_d;
      scan_q <= scan_d;
      col_q  <= col_d;
      row_q  <= row_d;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
    end
  end

  assign vm.counter_x     = cx_q;
  assign vm.counter_y     = cy_q;
  assign vm.frame_start   = fs_q;
  assign vm.isDrawAreaVGA = draw_q;
  assign vm.isOsdBgArea   = bg_q;
  assign vm.isOsdTextArea = text_q;
  assign vm.isScanline    = scan_q;
  assign vm.char_col      = col_q;
  assign vm.char_row      = row_q;
  assign vm.glyph_x       = gx_q;
  assign vm.glyph_y       = gy_q;

endmodule

// File: tb/tb_video_meta_gen.sv
// Bench for video_meta_gen on a shortened raster: per-cycle model compare plus literal pixel points.
// Works with and without VIDEO_META_FRAME_SYNC_EN.
module tb_video_meta_gen;
  localparam int HT = 180, VT = 92, HA = 160, VA = 88, BORDER = 4;
  localparam int FRAME = HT * VT;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  video_meta_if vif ();

  video_meta_gen #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .OSD_BORDER(BORDER)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .vm     (vif)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       fs, draw, bg, text, scan;
    logic [5:0] col;
    logic [4:0] row;
    logic [2:0] gx;
    logic [3:0] gy;
  } meta_t;

  typedef struct packed {
    logic       en;
    logic [9:0] ox, oy;
    logic [5:0] cols;
    logic [4:0] rows;
    logic       sen, sodd;
  } cfg_t;

  typedef struct {
    int ph, fr, x, y;
    logic [3:0] f;
    int col, row, gx, gy;
  } pt_t;

  int total = 0, bad = 0;
  int phase = 0, fs_count = 0, since = 0;
  bit seen = 1'b0;
  pt_t pts[$];
  bit  hits[64];

  meta_t got, exp_m;
  cfg_t  live, shadow;
  int    mx, my;
`ifdef VIDEO_META_FRAME_SYNC_EN
  bit    first_edge;
`endif

  assign got  = {vif.counter_x, vif.counter_y, vif.frame_start, vif.isDrawAreaVGA,
                 vif.isOsdBgArea, vif.isOsdTextArea, vif.isScanline, vif.char_col,
                 vif.char_row, vif.glyph_x, vif.glyph_y};
  assign live = {vif.osd_enable, vif.osd_x, vif.osd_y, vif.osd_cols, vif.osd_rows,
                 vif.scanline_enable, vif.scanline_odd};

  // What the pixel (x,y) must look like under configuration c, straight from the rules.
  function automatic meta_t model_pixel(input int x, input int y, input cfg_t c);
    meta_t m;
    int tx0, tx1, ty0, ty1, bx0, bx1, by0, by1;
    bit draw, in_tr, in_br;
    m = '0;
    m.x = 10'(x);
    m.y = 10'(y);
    m.fs = (x == 0) && (y == 0);
    draw = (x < HA) && (y < VA);
    tx0 = int'(c.ox);
    ty0 = int'(c.oy);
    tx1 = tx0 + 8 * int'(c.cols);
    ty1 = ty0 + 16 * int'(c.rows);
    bx0 = (tx0 < BORDER) ? 0 : tx0 - BORDER;
    by0 = (ty0 < BORDER) ? 0 : ty0 - BORDER;
    bx1 = tx1 + BORDER;
    by1 = ty1 + BORDER;
    in_tr = (x >= tx0) && (x < tx1) && (y >= ty0) && (y < ty1);
    in_br = (x >= bx0) && (x < bx1) && (y >= by0) && (y < by1);
    m.draw = draw;
    m.bg = c.en && (c.cols != 0) && (c.rows != 0) && in_br && draw;
    m.text = m.bg && in_tr;
    m.scan = c.sen && draw && ((y % 2) == int'(c.sodd));
    if (m.text) begin
      m.col = 6'((x - tx0) / 8);
      m.gx  = 3'((x - tx0) % 8);
      m.row = 5'((y - ty0) / 16);
      m.gy  = 4'((y - ty0) % 16);
    end
    return m;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_m  <= '0;
      mx     <= 0;
      my     <= 0;
      shadow <= '0;
`ifdef VIDEO_META_FRAME_SYNC_EN
      first_edge <= 1'b1;
`endif
    end else begin
      exp_m <= model_pixel(mx, my, shadow);
`ifdef VIDEO_META_FRAME_SYNC_EN
      if (first_edge || (mx == HT - 1 && my == VT - 1)) shadow <= live;
      first_edge <= 1'b0;
`else
      shadow <= live;
`endif
      if (mx == HT - 1) begin
        mx <= 0;
        my <= (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx <= mx + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      fs_count = 0;
      since    = 0;
      seen     = 1'b0;
    end else begin
      if (got.fs) begin
        if (seen) begin
          total++;
          if (since != FRAME) begin
            bad++;
            $display("FAIL frame_period got=%0d want=%0d", since, FRAME);
          end
        end
        fs_count++;
        seen  = 1'b1;
        since = 0;
      end
      since++;
      for (int i = 0; i < pts.size(); i++) begin
        if (pts[i].ph == phase && pts[i].fr == fs_count &&
            int'(got.x) == pts[i].x && int'(got.y) == pts[i].y) begin
          hits[i] = 1'b1;
          total++;
          if ({got.draw, got.bg, got.text, got.scan} !== pts[i].f ||
              int'(got.col) != pts[i].col || int'(got.row) != pts[i].row ||
              int'(got.gx) != pts[i].gx || int'(got.gy) != pts[i].gy) begin
            bad++;
            $display("FAIL point%0d (%0d,%0d) got dbts=%b col=%0d row=%0d gx=%0d gy=%0d want dbts=%b col=%0d row=%0d gx=%0d gy=%0d",
                     i, pts[i].x, pts[i].y, {got.draw, got.bg, got.text, got.scan},
                     got.col, got.row, got.gx, got.gy, pts[i].f, pts[i].col, pts[i].row,
                     pts[i].gx, pts[i].gy);
          end
        end
      end
    end
    total++;
    if (got !== exp_m) begin
      bad++;
      $display("FAIL per_cycle t=%0t got=%h want=%h (got x=%0d y=%0d, want x=%0d y=%0d)",
               $time, got, exp_m, got.x, got.y, exp_m.x, exp_m.y);
    end
  end

  task automatic add_pt(input int ph, input int fr, input int x, input int y,
                        input logic [3:0] f, input int col, input int row,
                        input int gx, input int gy);
    pt_t p;
    p = '{ph, fr, x, y, f, col, row, gx, gy};
    pts.push_back(p);
  endtask

  task automatic set_cfg(input bit en, input int ox, input int oy, input int cols,
                         input int rows, input bit sen, input bit sodd);
    vif.osd_enable      = en;
    vif.osd_x           = 10'(ox);
    vif.osd_y           = 10'(oy);
    vif.osd_cols        = 6'(cols);
    vif.osd_rows        = 5'(rows);
    vif.scanline_enable = sen;
    vif.scanline_odd    = sodd;
  endtask

  task automatic wait_until(input int fr, input int y, input int budget);
    int n = 0;
    while (!(fs_count == fr && int'(vif.counter_y) == y) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_timeout got frame=%0d y=%0d want frame=%0d y=%0d",
               fs_count, vif.counter_y, fr, y);
    end
  endtask

  task automatic release_and_check_first();
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    total++;
    // First pixel uses the reset-cleared shadow: only draw and frame_start are set.
    if (got.x != 0 || got.y != 0 || got.fs !== 1'b1 || got.draw !== 1'b1 ||
        got.bg !== 1'b0 || got.text !== 1'b0 || got.scan !== 1'b0) begin
      bad++;
      $display("FAIL first_pixel got x=%0d y=%0d fs=%b dbts=%b want x=0 y=0 fs=1 dbts=1000",
               got.x, got.y, got.fs, {got.draw, got.bg, got.text, got.scan});
    end
  endtask

  task automatic assert_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_clear got=%h want=0", got);
    end
  endtask

  initial begin
    set_cfg(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Phase 1: OSD at (100,50) 4x2 cells, odd scanlines
    add_pt(1, 1, 159, 0, 4'b1000, 0, 0, 0, 0);
    add_pt(1, 1, 160, 0, 4'b0000, 0, 0, 0, 0);
    add_pt(1, 1, 5, 89, 4'b0000, 0, 0, 0, 0);
    add_pt(1, 1, 5, 1, 4'b1001, 0, 0, 0, 0);
    add_pt(1, 1, 5, 0, 4'b1000, 0, 0, 0, 0);
    add_pt(1, 1, 95, 50, 4'b1000, 0, 0, 0, 0);
    add_pt(1, 1, 96, 46, 4'b1100, 0, 0, 0, 0);
    add_pt(1, 1, 100, 50, 4'b1110, 0, 0, 0, 0);
    add_pt(1, 1, 131, 81, 4'b1111, 3, 1, 7, 15);
    add_pt(1, 1, 132, 81, 4'b1101, 0, 0, 0, 0);
    add_pt(1, 1, 136, 81, 4'b1001, 0, 0, 0, 0);
    add_pt(1, 1, 135, 85, 4'b1101, 0, 0, 0, 0);
    add_pt(1, 1, 135, 86, 4'b1000, 0, 0, 0, 0);
`ifdef VIDEO_META_FRAME_SYNC_EN
    add_pt(1, 2, 100, 60, 4'b1110, 0, 0, 0, 10);
`else
    add_pt(1, 2, 100, 60, 4'b1000, 0, 0, 0, 0);
`endif
    add_pt(1, 3, 100, 60, 4'b1000, 0, 0, 0, 0);
    add_pt(1, 3, 121, 61, 4'b1111, 0, 0, 1, 11);
    // Phase 2: zero columns, even scanlines
    add_pt(2, 1, 100, 50, 4'b1001, 0, 0, 0, 0);
    add_pt(2, 1, 5, 1, 4'b1000, 0, 0, 0, 0);
    // Phase 3: osd_x=2, background left edge saturates at 0
    add_pt(3, 1, 0, 50, 4'b1101, 0, 0, 0, 0);
    add_pt(3, 1, 2, 50, 4'b1111, 0, 0, 0, 0);
    add_pt(3, 1, 0, 46, 4'b1101, 0, 0, 0, 0);
    add_pt(3, 1, 0, 45, 4'b1000, 0, 0, 0, 0);

    repeat (4) @(negedge clock);
    #1;
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=0", got);
    end

    set_cfg(1'b1, 100, 50, 4, 2, 1'b1, 1'b1);
    phase = 1;
    release_and_check_first();
    wait_until(2, 40, 3 * FRAME);
    vif.osd_x = 10'd120;
    wait_until(3, 62, 2 * FRAME);

    assert_reset();
    set_cfg(1'b1, 100, 50, 0, 2, 1'b1, 1'b0);
    phase = 2;
    repeat (3) @(negedge clock);
    release_and_check_first();
    wait_until(1, 62, FRAME);

    assert_reset();
    set_cfg(1'b1, 2, 50, 4, 2, 1'b1, 1'b0);
    phase = 3;
    repeat (3) @(negedge clock);
    release_and_check_first();
    wait_until(1, 62, FRAME);
    repeat (2) @(negedge clock);

    for (int i = 0; i < pts.size(); i++) begin
      if (!hits[i]) begin
        total++;
        bad++;
        $display("FAIL point%0d_missed got hit=0 want hit=1 at (%0d,%0d)", i, pts[i].x, pts[i].y);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
